// File: rtl/pe_cfg_pkg.sv
// pe_cfg_pkg: shared command, state and bus types for the PE configuration chain loader
package pe_cfg_pkg;
  typedef enum logic [1:0] {SELECT = 2'd0, WORD = 2'd1, SWAP = 2'd2, START = 2'd3} cmd_op_e;
  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} ld_state_e;
  typedef struct packed {
    logic [63:0] inst;
    logic [1:0]  id;
    logic        valid;
    logic        w_switch;
    logic        r_switch;
    logic        start;
  } pe_cfg_t;
endpackage

// File: rtl/pe_cfg_loader.sv
// pe_cfg_loader: sequences imem loads, bank swaps and global start onto the PE config chain
module pe_cfg_loader
  import pe_cfg_pkg::*;
#(
  parameter int INST_WIDTH = 64,
  parameter int INST_WORD  = 32,
  parameter int ID         = 2,
  parameter int NUM_PE     = 4,
  parameter int CONF       = INST_WIDTH + ID + 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [ID-1:0]                cmd_pe_id,
  input  logic [INST_WIDTH-1:0]        cmd_inst,
  output logic [CONF-1:0]              pe_config_out,
  output logic [$clog2(INST_WORD):0]   word_cnt,
  output logic                         busy,
  output logic                         err
);
  localparam int WCW = $clog2(INST_WORD) + 1;
  localparam int DCW = $clog2(NUM_PE + 1);
  localparam logic [WCW-1:0] WMAX = WCW'(INST_WORD);
  localparam logic [ID:0]    NPE  = (ID + 1)'(NUM_PE);
  localparam logic [DCW-1:0] NDR  = DCW'(NUM_PE);
  ld_state_e             state;
  cmd_op_e               op;
  logic [DCW-1:0]        drain_cnt;
  logic [INST_WIDTH-1:0] inst_q;
  logic [ID-1:0]         id_q, tgt;
  logic                  tgt_ok, valid_q, w_q, r_q, start_q, acc;
  assign cmd_ready     = state == IDLE;
  assign busy          = state == DRAIN;
  assign acc           = cmd_valid && cmd_ready;
  assign op            = cmd_op_e'(cmd_op);
  assign pe_config_out = {inst_q, id_q, valid_q, w_q, r_q, start_q};
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      inst_q    <= '0;
      id_q      <= '0;
      tgt       <= '0;
      tgt_ok    <= 1'b0;
      valid_q   <= 1'b0;
      w_q       <= 1'b0;
      r_q       <= 1'b0;
      start_q   <= 1'b0;
      word_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      start_q <= 1'b0;
      // drain holds off new commands until the start has walked the whole chain
      if (busy) begin
        drain_cnt <= drain_cnt - 1'b1;
        if (drain_cnt == DCW'(1)) state <= IDLE;
      end
      if (acc)
        case (op)
          SELECT:
            if ({1'b0, cmd_pe_id} < NPE) begin
              tgt      <= cmd_pe_id;
              tgt_ok   <= 1'b1;
              word_cnt <= '0;
            end else err <= 1'b1;
          WORD:
            if (!tgt_ok || word_cnt >= WMAX) err <= 1'b1;
            else begin
              inst_q   <= cmd_inst;
              id_q     <= tgt;
              valid_q  <= 1'b1;
              word_cnt <= word_cnt + 1'b1;
            end
          SWAP: begin
            w_q <= ~w_q;
            r_q <= ~r_q;
          end
          default: begin
            start_q   <= 1'b1;
            state     <= DRAIN;
            drain_cnt <= NDR;
          end
        endcase
    end
endmodule

// File: tb/tb_pe_cfg_loader.sv
// tb_pe_cfg_loader: scoreboard bench for the PE config chain loader
module tb_pe_cfg_loader;
  import pe_cfg_pkg::*;
  localparam int IW = 64, NW = 32, IDW = 2, NP = 4, CW = IW + IDW + 4, WCW = $clog2(NW) + 1;
  logic clk = 0, rst = 1, cmd_valid = 0;
  logic [1:0] cmd_op = 0;
  logic [IDW-1:0] cmd_pe_id = 0;
  logic [IW-1:0] cmd_inst = 0;
  logic cmd_ready, busy, err, ready3, busy3, err3;
  logic [CW-1:0] pe_config_out, cfg3;
  logic [WCW-1:0] word_cnt, wc3;
  typedef struct packed {
    logic [CW-1:0]  cfg;
    logic [WCW-1:0] wc;
    logic           busy;
    logic           err;
    logic           ready;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  int m_tgt = -1, m_wc = 0, m_drain = 0;
  logic m_err = 0, m_w = 0, m_r = 0;
  logic [IW-1:0] m_inst = 0;
  logic [IDW-1:0] m_id = 0;
  always #5 clk = ~clk;
  pe_cfg_loader u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_pe_id(cmd_pe_id), .cmd_inst(cmd_inst), .pe_config_out(pe_config_out),
    .word_cnt(word_cnt), .busy(busy), .err(err)
  );
  // three-PE chain so that an out-of-range SELECT id is expressible
  pe_cfg_loader #(.NUM_PE(3)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready3), .cmd_op(cmd_op),
    .cmd_pe_id(cmd_pe_id), .cmd_inst(cmd_inst), .pe_config_out(cfg3),
    .word_cnt(wc3), .busy(busy3), .err(err3)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [1:0] op, input int id, input logic [IW-1:0] inst);
    logic acc, vld, st;
    exp_t e;
    @(negedge clk);
    rst = r; cmd_valid = v; cmd_op = op; cmd_pe_id = IDW'(id); cmd_inst = inst;
    vld = 0; st = 0;
    if (r) begin
      m_tgt = -1; m_wc = 0; m_drain = 0; m_err = 0; m_w = 0; m_r = 0; m_inst = 0; m_id = 0;
    end else begin
      acc = v && m_drain == 0;
      if (m_drain > 0) m_drain--;
      if (acc)
        case (op)
          2'd0: if (id < NP) begin m_tgt = id; m_wc = 0; end else m_err = 1;
          2'd1: if (m_tgt < 0 || m_wc >= NW) m_err = 1;
                else begin m_inst = inst; m_id = IDW'(m_tgt); vld = 1; m_wc++; end
          2'd2: begin m_w = ~m_w; m_r = ~m_r; end
          default: begin st = 1; m_drain = NP; end
        endcase
    end
    e.cfg = {m_inst, m_id, vld, m_w, m_r, st};
    e.wc = WCW'(m_wc);
    e.busy = m_drain > 0;
    e.err = m_err;
    e.ready = m_drain == 0;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check("cfg", pe_config_out, e.cfg);
    check("word_cnt", word_cnt, e.wc);
    check("busy", busy, e.busy);
    check("err", err, e.err);
    check("ready", cmd_ready, e.ready);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'd0, 0, '0);
  endtask
  initial begin
    step(1, 1, 2'd1, 0, 64'hDEAD);
    step(1, 0, 2'd0, 0, '0);
    step(0, 1, 2'd1, 0, 64'h1234);
    step(0, 1, 2'd0, 1, '0);
    step(0, 1, 2'd1, 0, 64'hA5A5_0000_0000_0001);
    idle(1);
    step(0, 1, 2'd0, 2, '0);
    for (int i = 0; i < NW + 1; i++) step(0, 1, 2'd1, 0, {$urandom, $urandom});
    idle(1);
    step(0, 1, 2'd2, 0, '0);
    idle(2);
    step(0, 1, 2'd2, 0, '0);
    idle(1);
    step(0, 1, 2'd0, 0, '0);
    step(0, 1, 2'd3, 0, '0);
    for (int i = 0; i < NP + 2; i++) step(0, 1, 2'd1, 0, 64'h100 + 64'(i));
    step(0, 1, 2'd3, 0, '0);
    idle(2);
    step(1, 1, 2'd1, 0, 64'hBEEF);
    idle(1);
    step(1, 0, 2'd0, 0, '0);
    step(0, 1, 2'd0, 3, '0);
    check("oob_select_err", err3, 1'b1);
    step(0, 1, 2'd1, 0, 64'h77);
    check("oob_select_no_pulse", cfg3[3], 1'b0);
    step(1, 0, 2'd0, 0, '0);
    step(0, 1, 2'd0, 2, '0);
    check("in_range_select_err", err3, 1'b0);
    step(0, 1, 2'd1, 0, 64'h88);
    check("in_range_pulse", cfg3[3], 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
